adder_inc: RTL and testbench
============================

Name: adder_inc

Overview:
- Parameterised WIDTH-bit incrementer: out = a + en, with carry-out.
- Used by the pager to form next-page addresses, e.g. new_addr[47:14] + 1 (WIDTH=34) and new_addr[47:23] + 1 (WIDTH=25).
- Default configuration is purely combinational.
- An optional single output-register stage (LATENCY=1) uses the block's clock and reset.

Parameters:
- WIDTH, default 32: operand and result width in bits; legal range ≥1.
- LATENCY, default 0: 0 = combinational outputs; 1 = outputs registered once on clk.

Ports:
- clk  input  1  clock; used only when LATENCY=1.
- rst  input  1  reset; used only when LATENCY=1.
- a  input  WIDTH  operand.
- out  output  WIDTH  a + en, modulo 2^WIDTH.
- en  input  1  increment enable / carry-in; 0 passes a through unchanged.
- cout  output  1  carry out of bit WIDTH-1; callers may leave it unconnected.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high (clk, rst).
- Port order is clk, rst, a, out, en, cout. Instantiate by named connection.
- Arithmetic rules:
  - out[i] = a[i] XOR (en AND a[0] AND … AND a[i-1]); out[0] = a[0] XOR en.
  - cout = en AND (&a).
  - Wrap-around: a = all-ones with en=1 gives out = 0 and cout = 1.
  - en=0 gives out = a and cout = 0 for every a.
- Carry structure:
  - The prefix-AND carry chain must be log-depth: a parallel-prefix (Kogge-Stone style) tree of ceil(log2(WIDTH)) levels.
  - It must be generated from WIDTH; no behavioural '+' operator.
  - Must synthesise correctly for any WIDTH ≥ 1, including non-powers of two (34, 25) and WIDTH=1.
  - For WIDTH=1: out = a ^ en, cout = a & en.
- LATENCY=0:
  - Outputs are a pure function of a and en, with zero cycles of latency.
  - clk and rst have no effect.
  - No latches; no X-propagation beyond X inputs.
- LATENCY=1:
  - At each rising clk edge: if rst=1, out←0 and cout←0; else out←f(a,en) and cout←g(a,en).
  - Latency is one cycle. There is no stall or valid handshake; a new operand is accepted every cycle.
  - Reset asserted mid-stream takes priority at that edge. Outputs show the result of the first post-reset operand one cycle after rst deasserts.
- Any LATENCY value other than 0 or 1 is illegal and must raise an elaboration-time error.
- No internal state exists other than the LATENCY=1 output registers.

Test Plan:
- WIDTH=34, LATENCY=0, a=34'h0_0000_0000, en=1 → out=34'h0_0000_0001, cout=0. Same a with en=0 → out=0, cout=0.
- WIDTH=34, a=34'h3_FFFF_FFFF, en=1 → out=0, cout=1 (wrap). With en=0 → out=34'h3_FFFF_FFFF, cout=0.
- WIDTH=34, a=34'h0_0000_FFFF, en=1 → out=34'h0_0001_0000 (long carry ripple through a non-power-of-two tree). WIDTH=25, a=25'h0FF_FFFF, en=1 → out=25'h100_0000, cout=0.
- WIDTH=1 exhaustive: (a,en) = 00,01,10,11 → (out,cout) = 00,10,10,01.
- LATENCY=1, WIDTH=34:
  - Hold rst=1 for 2 cycles → out=0, cout=0.
  - Release rst, apply a=34'h1_2345_6789, en=1 → one cycle later out=34'h1_2345_678A.
  - Assert rst while a=all-ones → next edge out=0, cout=0 (not 0/1).
- Random self-check:
  - 10k random (a,en) pairs for WIDTH ∈ {1, 8, 25, 34, 64} against a reference model {cout,out} = a + en.
  - Include directed vectors with a = all-ones and with each single zero bit position.

Source files
------------

// File: rtl/adder_inc.sv
// ---------------------------------------------------------------------------
// adder_inc
//   Parameterised WIDTH-bit incrementer: {cout, out} = a + en.
//   The carry into each bit is the prefix AND of the lower operand bits,
//   gated by en. It is built as a Kogge-Stone parallel-prefix tree of
//   ceil(log2(WIDTH)) levels, so depth grows logarithmically with WIDTH.
//   The tree works for any WIDTH >= 1, including non-powers of two.
//
//   Parameters
//     WIDTH   : operand/result width in bits (>= 1)
//     LATENCY : 0 = combinational outputs, 1 = one output register stage
//
//   Ports
//     clk  : clock, only used when LATENCY = 1
//     rst  : synchronous active-high reset, only used when LATENCY = 1
//     a    : operand
//     out  : a + en, modulo 2^WIDTH
//     en   : increment enable / carry-in (0 passes a through)
//     cout : carry out of bit WIDTH-1 (may be left unconnected)
// ---------------------------------------------------------------------------
module adder_inc #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out,
    input  logic             en,
    output logic             cout
);

    // A single-bit operand needs no prefix levels at all.
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    // Row k holds, for each bit i, the AND of a[i] down to a[i-2^k+1]
    // (saturating at bit 0). The last row is the full inclusive prefix AND.
    logic [LEVELS:0][WIDTH-1:0] prefix_tree;
    logic [WIDTH-1:0]           carry;
    logic [WIDTH-1:0]           out_d;
    logic                       cout_d;

    // Kogge-Stone prefix tree. Each level combines every bit with the bit
    // 2^lvl positions below it. Bits with no partner at that distance
    // already hold their full prefix and pass straight through.
    always_comb begin
        prefix_tree    = '0;
        prefix_tree[0] = a;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << lvl)) begin
                    prefix_tree[lvl+1][i] = prefix_tree[lvl][i]
                                          & prefix_tree[lvl][i-(1 << lvl)];
                end else begin
                    prefix_tree[lvl+1][i] = prefix_tree[lvl][i];
                end
            end
        end
    end

    // The carry into bit i is en ANDed with the prefix AND of a[i-1:0].
    // en is applied after the tree. This keeps the tree at
    // ceil(log2(WIDTH)) levels rather than one more for the carry-in.
    always_comb begin
        carry    = '0;
        carry[0] = en;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = en & prefix_tree[LEVELS][i-1];
        end
        out_d  = a ^ carry;
        cout_d = en & prefix_tree[LEVELS][WIDTH-1];
    end

    generate
        if (LATENCY == 0) begin : g_comb
            // clk and rst are intentionally unused in the combinational form.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out            = out_d;
            assign cout           = cout_d;
        end else if (LATENCY == 1) begin : g_reg
            logic [WIDTH-1:0] out_q;
            logic             cout_q;

            // Single output register stage. Reset wins over new data at the
            // same edge. A new operand is accepted every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q  <= '0;
                    cout_q <= 1'b0;
                end else begin
                    out_q  <= out_d;
                    cout_q <= cout_d;
                end
            end

            assign out  = out_q;
            assign cout = cout_q;
        end else begin : g_bad_latency
            $error("adder_inc: LATENCY must be 0 or 1");
        end
    endgenerate

endmodule

// File: tb/tb_adder_inc.sv
// ---------------------------------------------------------------------------
// tb_adder_inc
//   Scoreboard bench for adder_inc. Six instances share one stimulus stream:
//   combinational widths 1, 8, 25, 34 and 64, plus a registered width-34
//   instance. Stimulus pushes the expected {cout, out} into one queue per
//   instance. A monitor on the falling edge pops each queue and compares it
//   whenever that instance presents a result.
//
//   Expected values are computed in one of two ways:
//     - hand-written constants for the directed vectors;
//     - a reference model {cout, out} = a + en for the other vectors.
// ---------------------------------------------------------------------------
module tb_adder_inc;

    typedef logic [64:0] resp_t;

    logic        clk = 1'b0;
    logic        rst_drv = 1'b1;
    logic [63:0] a_drv = '0;
    logic        en_drv = 1'b0;

    logic        issue_comb = 1'b0;
    logic        issue_reg = 1'b0;
    logic        reg_vld = 1'b0;

    int          total = 0;
    int          bad = 0;

    resp_t q1[$], q8[$], q25[$], q34[$], q64[$], q34r[$];

    logic [0:0]  out1;
    logic [7:0]  out8;
    logic [24:0] out25;
    logic [33:0] out34;
    logic [63:0] out64;
    logic [33:0] out34r;
    logic        cout1, cout8, cout25, cout34, cout64, cout34r;

    always #5 clk = ~clk;

    adder_inc #(.WIDTH(1),  .LATENCY(0)) u_w1 (
        .clk(clk), .rst(rst_drv), .a(a_drv[0:0]), .out(out1), .en(en_drv), .cout(cout1));
    adder_inc #(.WIDTH(8),  .LATENCY(0)) u_w8 (
        .clk(clk), .rst(rst_drv), .a(a_drv[7:0]), .out(out8), .en(en_drv), .cout(cout8));
    adder_inc #(.WIDTH(25), .LATENCY(0)) u_w25 (
        .clk(clk), .rst(rst_drv), .a(a_drv[24:0]), .out(out25), .en(en_drv), .cout(cout25));
    adder_inc #(.WIDTH(34), .LATENCY(0)) u_w34 (
        .clk(clk), .rst(rst_drv), .a(a_drv[33:0]), .out(out34), .en(en_drv), .cout(cout34));
    adder_inc #(.WIDTH(64), .LATENCY(0)) u_w64 (
        .clk(clk), .rst(rst_drv), .a(a_drv), .out(out64), .en(en_drv), .cout(cout64));
    adder_inc #(.WIDTH(34), .LATENCY(1)) u_w34r (
        .clk(clk), .rst(rst_drv), .a(a_drv[33:0]), .out(out34r), .en(en_drv), .cout(cout34r));

    // Records one comparison and prints a FAIL line when it does not match.
    task automatic checkOutput(input string name, input resp_t act, input resp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Records a result that had no matching expected entry in its queue.
    task automatic noteMissing(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: output presented with empty scoreboard queue", name);
    endtask

    // Drives one vector and pushes the expectation for every instance.
    // Each hN flag replaces the model value with a hand-computed constant.
    task automatic applyStimulus(
        input logic [63:0] av, input logic ev, input logic rv,
        input logic h34 = 1'b0, input resp_t e34 = '0,
        input logic h25 = 1'b0, input resp_t e25 = '0,
        input logic h1  = 1'b0, input resp_t e1  = '0,
        input logic hr  = 1'b0, input resp_t er  = '0);
        resp_t m34;
        @(posedge clk);
        #1;
        a_drv   = av;
        en_drv  = ev;
        rst_drv = rv;
        m34     = resp_t'({1'b0, av[33:0]} + {34'd0, ev});
        q1.push_back(h1 ? e1 : resp_t'({1'b0, av[0]} + {1'b0, ev}));
        q8.push_back(resp_t'({1'b0, av[7:0]} + {8'd0, ev}));
        q25.push_back(h25 ? e25 : resp_t'({1'b0, av[24:0]} + {25'd0, ev}));
        q34.push_back(h34 ? e34 : m34);
        q64.push_back({1'b0, av} + {64'd0, ev});
        q34r.push_back(hr ? er : (rv ? resp_t'(0) : m34));
        issue_comb = 1'b1;
        issue_reg  = 1'b1;
    endtask

    // Registered results appear one edge after their operand was applied.
    always @(posedge clk) begin
        reg_vld <= issue_reg;
    end

    // Monitor: combinational results are checked in the cycle they are
    // driven. Registered results are checked once reg_vld says one is present.
    always @(negedge clk) begin
        if (issue_comb) begin
            if (q1.size() == 0) noteMissing("w1");
            else checkOutput("w1", {cout1, out1}, q1.pop_front());
            if (q8.size() == 0) noteMissing("w8");
            else checkOutput("w8", {cout8, out8}, q8.pop_front());
            if (q25.size() == 0) noteMissing("w25");
            else checkOutput("w25", {cout25, out25}, q25.pop_front());
            if (q34.size() == 0) noteMissing("w34");
            else checkOutput("w34", {cout34, out34}, q34.pop_front());
            if (q64.size() == 0) noteMissing("w64");
            else checkOutput("w64", {cout64, out64}, q64.pop_front());
        end
        if (reg_vld) begin
            if (q34r.size() == 0) noteMissing("w34r");
            else checkOutput("w34r", {cout34r, out34r}, q34r.pop_front());
        end
    end

    // Guards against a hung run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] av;
        $display("[TB] starting adder_inc scoreboard bench");

        // Registered instance: hold reset for two cycles; the outputs must be zero.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h0);
        // Release reset with a known operand.
        applyStimulus(64'h0000_0001_2345_6789, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h1_2345_678A);
        // Reset mid-stream while a is all ones: expect 0/0, not a wrap to 0/1.
        applyStimulus(64'h0000_0003_FFFF_FFFF, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h0);

        // Directed width-34 and width-25 vectors.
        applyStimulus(64'h0, 1'b1, 1'b0, 1'b1, 65'h0_0000_0001);
        applyStimulus(64'h0, 1'b0, 1'b0, 1'b1, 65'h0);
        applyStimulus(64'h0000_0003_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 65'h4_0000_0000);
        applyStimulus(64'h0000_0003_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 65'h3_FFFF_FFFF);
        applyStimulus(64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b1, 65'h0_0001_0000);
        applyStimulus(64'h0000_0000_00FF_FFFF, 1'b1, 1'b0, 1'b0, '0, 1'b1, 65'h100_0000);

        // Width 1, exhaustive ({cout, out}): 00->0, 01->1, 10->1, 11->2.
        applyStimulus(64'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h0);
        applyStimulus(64'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h1);
        applyStimulus(64'h1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h1);
        applyStimulus(64'h1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 65'h2);

        // All ones, then each single-zero-bit position, at every width.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            av = ~(64'd1 << i);
            applyStimulus(av, 1'b1, 1'b0);
        end

        // Random operands, with an occasional reset pulse on the registered instance.
        for (int n = 0; n < 10000; n++) begin
            av = {$urandom(), $urandom()};
            applyStimulus(av, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        // Stop issuing and let the registered stage drain.
        @(posedge clk);
        #1;
        issue_comb = 1'b0;
        issue_reg  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drain_q1",   resp_t'(q1.size()),   '0);
        checkOutput("drain_q34",  resp_t'(q34.size()),  '0);
        checkOutput("drain_q34r", resp_t'(q34r.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
